// File: rtl/control_sequencer.sv
// Hardwired control unit: sequences fetch (T0-T2) and execute (T3-T6) for the datapath,
// decoding the instruction register it presents back and driving every control strobe.
module control_sequencer #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned OPW   = 5
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [31:0]      IR,
    output logic             Run,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic             Cout,
    output logic [NREGS-1:0] R_in,
    output logic [NREGS-1:0] R_out,
    output logic [OPW-1:0]   opcode
);

    typedef enum logic [3:0] {
        StReset,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalted
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsImm,
        ClsMulDiv,
        ClsUnary,
        ClsHalt,
        ClsNop
    } cls_e;

    state_e state_q, state_d;
    cls_e   cls;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    function automatic logic [NREGS-1:0] sel(input logic [3:0] idx);
        sel = NREGS'(1) << idx;
    endfunction

    // Only meaningful from T3 onward, once the datapath has loaded IR.
    always_comb begin
        cls = ClsNop;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: cls = ClsAlu;
            5'b01100, 5'b01101, 5'b01110:           cls = ClsImm;
            5'b01111, 5'b10000:                     cls = ClsMulDiv;
            5'b10001, 5'b10010:                     cls = ClsUnary;
            5'b11011:                               cls = ClsHalt;
            default:                                cls = ClsNop;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StT0;
            StT0:     state_d = StT1;
            StT1:     state_d = StT2;
            StT2:     state_d = StT3;
            StT3: begin
                case (cls)
                    ClsHalt: state_d = StHalted;
                    ClsNop:  state_d = StT0;
                    default: state_d = StT4;
                endcase
            end
            StT4:     state_d = (cls == ClsUnary) ? StT0 : StT5;
            StT5:     state_d = (cls == ClsMulDiv) ? StT6 : StT0;
            StT6:     state_d = StT0;
            StHalted: state_d = StHalted;
            default:  state_d = StReset;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of state plus IR; exactly one bus driver per state at most.
    always_comb begin
        Run      = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Cout     = 1'b0;
        R_in     = '0;
        R_out    = '0;
        opcode   = '0;
        unique case (state_q)
            StReset, StHalted: ;
            StT0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                PCin  = 1'b1;
            end
            StT1: begin
                Run   = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            StT2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                Run = 1'b1;
                case (cls)
                    ClsAlu, ClsImm: begin
                        R_out = sel(rb);
                        Yin   = 1'b1;
                    end
                    ClsMulDiv: begin
                        R_out = sel(ra);
                        Yin   = 1'b1;
                    end
                    ClsUnary: begin
                        R_out  = sel(rb);
                        Zin    = 1'b1;
                        opcode = OPW'(op);
                    end
                    default: ;
                endcase
            end
            StT4: begin
                Run = 1'b1;
                case (cls)
                    ClsAlu: begin
                        R_out  = sel(rc);
                        Zin    = 1'b1;
                        opcode = OPW'(op);
                    end
                    ClsImm: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        opcode = OPW'(op);
                    end
                    ClsMulDiv: begin
                        R_out  = sel(rb);
                        Zin    = 1'b1;
                        opcode = OPW'(op);
                    end
                    ClsUnary: begin
                        Zlowout = 1'b1;
                        R_in    = sel(ra);
                    end
                    default: ;
                endcase
            end
            StT5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                if (cls == ClsMulDiv) begin
                    LOin = 1'b1;
                end else begin
                    R_in = sel(ra);
                end
            end
            StT6: begin
                Run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
